// File: rtl/dual_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// dual_issue_scoreboard
//
// Register-hazard scoreboard for the dual-issue integer pipeline. It keeps a
// small counter of in-flight writes for every architectural register. It
// grants or blocks each issue slot from source readiness, intra-pair
// dependence and destination counter capacity. It retires tracking when the
// two writeback ports write the register file. Readiness accounts for the
// register file's same-cycle write-through bypass.
//
// Optional build macro: SB_STATS_EN adds the stall_cnt output (stall events).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               clears all pending state on the next edge
//   iss_req_1/2         issue requests for slot 1 / slot 2
//   iss_waddr_1/2       destinations (0 = no write)
//   iss_raddr_1a/1b     slot-1 sources (read ports 1,2)
//   iss_raddr_2a/2b     slot-2 sources (read ports 3,4)
//   issue_ok_1/2        combinational grants for the current cycle
//   wb_ena_1/2          writeback port enables
//   wb_addr_1/2         writeback addresses
//   pending             registered view, bit r = counter[r] != 0
//   stall_cnt           (SB_STATS_EN only) wrapping stall event count
//   err                 sticky: writeback to a non-zero register with no
//                       pending write
// ---------------------------------------------------------------------------
module dual_issue_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            iss_req_1,
  input  logic [4:0]      iss_waddr_1,
  input  logic [4:0]      iss_raddr_1a,
  input  logic [4:0]      iss_raddr_1b,
  input  logic            iss_req_2,
  input  logic [4:0]      iss_waddr_2,
  input  logic [4:0]      iss_raddr_2a,
  input  logic [4:0]      iss_raddr_2b,
  output logic            issue_ok_1,
  output logic            issue_ok_2,
  input  logic            wb_ena_1,
  input  logic            wb_ena_2,
  input  logic [4:0]      wb_addr_1,
  input  logic [4:0]      wb_addr_2,
  output logic [NREG-1:0] pending,
`ifdef SB_STATS_EN
  output logic [31:0]     stall_cnt,
`endif
  output logic            err
);

  localparam int               AW       = 5;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r     [NREG];
  logic [CNT_W-1:0] cnt_nxt_s [NREG];
  logic [NREG-1:0]  pending_r;
  logic             err_r;
  logic             err_set_s;
  logic [NREG-1:0]  wb_hit_s;
  logic [NREG-1:0]  rdy_s;
  logic             cap1_s;
  logic             cap2_s;
  logic             raw_s;
  logic             ok1_s;
  logic             ok2_s;

  // Per-register writeback hit and source readiness (with write-through bypass)
  always_comb begin
    wb_hit_s = {NREG{1'b0}};
    rdy_s    = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        wb_hit_s[r] = 1'b0;
        rdy_s[r]    = 1'b1;
      end else begin
        wb_hit_s[r] = (wb_ena_1 && (wb_addr_1 == AW'(r))) ||
                      (wb_ena_2 && (wb_addr_2 == AW'(r)));
        // A last outstanding write landing this cycle is visible through the bypass;
        // two ports to the same register still retire only one write.
        rdy_s[r]    = (cnt_r[r] == CNT_ZERO) ||
                      ((cnt_r[r] == CNT_ONE) && wb_hit_s[r]);
      end
    end
  end

  // Slot grants: readiness, intra-pair RAW and destination counter capacity
  always_comb begin
    cap1_s = (iss_waddr_1 == 5'd0) || (cnt_r[iss_waddr_1] != CNT_MAX);
    if (iss_waddr_2 == 5'd0) begin
      cap2_s = 1'b1;
    end else if (iss_waddr_2 == iss_waddr_1) begin
      // Slot 1 also claims this destination in the same cycle.
      cap2_s = ({1'b0, cnt_r[iss_waddr_2]} + {{CNT_W{1'b0}}, 1'b1}) < {1'b0, CNT_MAX};
    end else begin
      cap2_s = (cnt_r[iss_waddr_2] != CNT_MAX);
    end
    raw_s = (iss_waddr_1 != 5'd0) &&
            ((iss_raddr_2a == iss_waddr_1) || (iss_raddr_2b == iss_waddr_1));
    ok1_s = iss_req_1 && rdy_s[iss_raddr_1a] && rdy_s[iss_raddr_1b] && cap1_s;
    ok2_s = iss_req_2 && ok1_s && rdy_s[iss_raddr_2a] && rdy_s[iss_raddr_2b] &&
            !raw_s && cap2_s;
  end

  assign issue_ok_1 = ok1_s;
  assign issue_ok_2 = ok2_s;

  // Next counter values: grants add, a writeback retires one, flush clears
  always_comb begin
    logic [CNT_W:0] sum_v;
    logic           g1_v;
    logic           g2_v;
    logic           dec_v;
    err_set_s = 1'b0;
    sum_v     = {(CNT_W+1){1'b0}};
    g1_v      = 1'b0;
    g2_v      = 1'b0;
    dec_v     = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        cnt_nxt_s[r] = CNT_ZERO;
      end else begin
        g1_v      = ok1_s && (iss_waddr_1 == AW'(r));
        g2_v      = ok2_s && (iss_waddr_2 == AW'(r));
        dec_v     = wb_hit_s[r] && (cnt_r[r] != CNT_ZERO);
        err_set_s = err_set_s | (wb_hit_s[r] && (cnt_r[r] == CNT_ZERO));
        sum_v     = {1'b0, cnt_r[r]} + {{CNT_W{1'b0}}, g1_v} + {{CNT_W{1'b0}}, g2_v}
                    - {{CNT_W{1'b0}}, dec_v};
        cnt_nxt_s[r] = flush ? CNT_ZERO : sum_v[CNT_W-1:0];
      end
    end
  end

  // Counter state, registered pending view and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      pending_r <= {NREG{1'b0}};
      err_r     <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r]     <= cnt_nxt_s[r];
        pending_r[r] <= (cnt_nxt_s[r] != CNT_ZERO);
      end
      err_r <= err_r | err_set_s;
    end
  end

  assign pending = pending_r;
  assign err     = err_r;

`ifdef SB_STATS_EN
  logic [31:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = (iss_req_1 && !ok1_s) || (iss_req_2 && ok1_s && !ok2_s);

  // Wrapping stall event counter, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_dual_issue_scoreboard
//
// Directed scenarios followed by randomized traffic, checked against a
// reference model that tracks in-flight write counts as plain integers.
// ---------------------------------------------------------------------------
module tb_dual_issue_scoreboard;

  localparam int NREG = 32;
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        iss_req_1, iss_req_2;
  logic [4:0]  iss_waddr_1, iss_raddr_1a, iss_raddr_1b;
  logic [4:0]  iss_waddr_2, iss_raddr_2a, iss_raddr_2b;
  logic        issue_ok_1, issue_ok_2;
  logic        wb_ena_1, wb_ena_2;
  logic [4:0]  wb_addr_1, wb_addr_2;
  logic [31:0] pending;
  logic        err;
`ifdef SB_STATS_EN
  logic [31:0] stall_cnt;
  int          m_stall;
`endif

  int checks = 0;
  int errors = 0;
  int m_cnt[NREG];
  bit m_err;

  dual_issue_scoreboard #(.NREG(NREG), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_req_1(iss_req_1), .iss_waddr_1(iss_waddr_1),
    .iss_raddr_1a(iss_raddr_1a), .iss_raddr_1b(iss_raddr_1b),
    .iss_req_2(iss_req_2), .iss_waddr_2(iss_waddr_2),
    .iss_raddr_2a(iss_raddr_2a), .iss_raddr_2b(iss_raddr_2b),
    .issue_ok_1(issue_ok_1), .issue_ok_2(issue_ok_2),
    .wb_ena_1(wb_ena_1), .wb_ena_2(wb_ena_2),
    .wb_addr_1(wb_addr_1), .wb_addr_2(wb_addr_2),
    .pending(pending),
`ifdef SB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    iss_req_1 = 1'b0; iss_waddr_1 = 5'd0; iss_raddr_1a = 5'd0; iss_raddr_1b = 5'd0;
    iss_req_2 = 1'b0; iss_waddr_2 = 5'd0; iss_raddr_2a = 5'd0; iss_raddr_2b = 5'd0;
    wb_ena_1 = 1'b0; wb_addr_1 = 5'd0; wb_ena_2 = 1'b0; wb_addr_2 = 5'd0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_err = 1'b0;
`ifdef SB_STATS_EN
    m_stall = 0;
`endif
  endtask

  function automatic bit m_wb(int a);
    return (wb_ena_1 && wb_addr_1 == a) || (wb_ena_2 && wb_addr_2 == a);
  endfunction

  function automatic bit m_rdy(int a);
    return (a == 0) || (m_cnt[a] == 0) || (m_cnt[a] == 1 && m_wb(a));
  endfunction

  // One clock: check grants against the model, advance, check registered state.
  task automatic cyc();
    int nc[NREG];
    int w1, w2;
    bit e1, e2;
    logic [31:0] ep;
    #1;
    w1 = iss_waddr_1;
    w2 = iss_waddr_2;
    e1 = iss_req_1 && m_rdy(iss_raddr_1a) && m_rdy(iss_raddr_1b) &&
         (w1 == 0 || m_cnt[w1] < MAXC);
    e2 = iss_req_2 && e1 && m_rdy(iss_raddr_2a) && m_rdy(iss_raddr_2b) &&
         !(w1 != 0 && (iss_raddr_2a == w1 || iss_raddr_2b == w1)) &&
         (w2 == 0 || m_cnt[w2] + ((w1 == w2) ? 1 : 0) < MAXC);
    check_val("issue_ok_1", issue_ok_1, e1);
    check_val("issue_ok_2", issue_ok_2, e2);
`ifdef SB_STATS_EN
    if ((iss_req_1 && !e1) || (iss_req_2 && e1 && !e2)) m_stall++;
`endif
    nc[0] = 0;
    for (int r = 1; r < NREG; r++) begin
      nc[r] = m_cnt[r] + ((e1 && w1 == r) ? 1 : 0) + ((e2 && w2 == r) ? 1 : 0);
      if (m_wb(r)) begin
        if (m_cnt[r] > 0) nc[r] = nc[r] - 1;
        else m_err = 1'b1;
      end
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++) nc[r] = 0;
    end
    @(posedge clk);
    #1;
    m_cnt = nc;
    idle();
    for (int r = 0; r < NREG; r++) ep[r] = (m_cnt[r] != 0);
    check_val("pending", pending, ep);
    check_val("err", err, m_err);
`ifdef SB_STATS_EN
    check_val("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // Prefer a register with writes outstanding so err stays meaningful.
  function automatic int pick_wb();
    for (int t = 0; t < 8; t++) begin
      int a;
      a = $urandom_range(1, 7);
      if (m_cnt[a] > 0) return a;
    end
    return 0;
  endfunction

  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_val({tag, "_pending"}, pending, 32'd0);
    check_val({tag, "_err"}, err, 1'b0);
`ifdef SB_STATS_EN
    check_val({tag, "_stall"}, stall_cnt, 32'd0);
`endif
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    check_val("rst_pending", pending, 32'd0);
    check_val("rst_err", err, 1'b0);
`ifdef SB_STATS_EN
    check_val("rst_stall", stall_cnt, 32'd0);
`endif

    // Single dependent chain through register 5, retired via the bypass.
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd5; iss_raddr_1a = 5'd5;
    #1; check_val("tp1_ok_first", issue_ok_1, 1'b1);
    cyc();
    check_val("tp1_pend5_set", pending[5], 1'b1);
    iss_req_1 = 1'b1; iss_raddr_1a = 5'd5;
    #1; check_val("tp1_ok_busy", issue_ok_1, 1'b0);
    cyc();
    iss_req_1 = 1'b1; iss_raddr_1a = 5'd5; wb_ena_1 = 1'b1; wb_addr_1 = 5'd5;
    #1; check_val("tp1_ok_bypass", issue_ok_1, 1'b1);
    cyc();
    check_val("tp1_pend5_clr", pending[5], 1'b0);

    // Intra-pair RAW and zero-register pair.
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd3; iss_req_2 = 1'b1; iss_raddr_2a = 5'd3;
    #1; check_val("tp2_raw_ok1", issue_ok_1, 1'b1);
    check_val("tp2_raw_ok2", issue_ok_2, 1'b0);
    cyc();
    iss_req_1 = 1'b1; iss_req_2 = 1'b1;
    #1; check_val("tp2_zero_ok2", issue_ok_2, 1'b1);
    cyc();
    wb_ena_1 = 1'b1; wb_addr_1 = 5'd3;
    cyc();

    // Counter saturation on register 7.
    repeat (3) begin
      iss_req_1 = 1'b1; iss_waddr_1 = 5'd7;
      cyc();
    end
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd7;
    #1; check_val("tp3_full_block", issue_ok_1, 1'b0);
    cyc();
    wb_ena_1 = 1'b1; wb_addr_1 = 5'd7;
    cyc();
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd7;
    #1; check_val("tp3_room_again", issue_ok_1, 1'b1);
    cyc();
    repeat (3) begin
      wb_ena_2 = 1'b1; wb_addr_2 = 5'd7;
      cyc();
    end
    check_val("tp3_pend7_clr", pending[7], 1'b0);

    // Dual writeback to one register retires once; stray writeback sets err.
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd9;
    cyc();
    wb_ena_1 = 1'b1; wb_addr_1 = 5'd9; wb_ena_2 = 1'b1; wb_addr_2 = 5'd9;
    cyc();
    check_val("tp4_err_clean", err, 1'b0);
    wb_ena_1 = 1'b1; wb_addr_1 = 5'd10;
    cyc();
    check_val("tp4_err_set", err, 1'b1);
    cyc();
    check_val("tp4_err_sticky", err, 1'b1);

    // Flush discards pending state and a same-cycle grant.
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd4; iss_req_2 = 1'b1; iss_waddr_2 = 5'd6;
    cyc();
    check_val("tp5_pend46", {pending[6], pending[4]}, 2'b11);
    flush = 1'b1; iss_req_1 = 1'b1; iss_waddr_1 = 5'd8;
    #1; check_val("tp5_flush_ok1", issue_ok_1, 1'b1);
    cyc();
    check_val("tp5_flush_pend", pending, 32'd0);
    check_val("tp5_flush_err", err, 1'b1);

    // Asynchronous reset mid-cycle with state held.
    iss_req_1 = 1'b1; iss_waddr_1 = 5'd12;
    cyc();
    async_reset_check("tp6_arst");

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      int a;
      iss_req_1    = ($urandom_range(0, 3) != 0);
      iss_waddr_1  = 5'($urandom_range(0, 7));
      iss_raddr_1a = 5'($urandom_range(0, 7));
      iss_raddr_1b = 5'($urandom_range(0, 7));
      iss_req_2    = ($urandom_range(0, 2) != 0);
      iss_waddr_2  = 5'($urandom_range(0, 7));
      iss_raddr_2a = 5'($urandom_range(0, 7));
      iss_raddr_2b = 5'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 40) == 0);
      if (!flush) begin
        a = pick_wb();
        wb_ena_1  = ($urandom_range(0, 2) != 0);
        wb_addr_1 = 5'(a);
        a = ($urandom_range(0, 3) == 0) ? int'(wb_addr_1) : pick_wb();
        wb_ena_2  = ($urandom_range(0, 2) != 0);
        wb_addr_2 = 5'(a);
        if ($urandom_range(0, 60) == 0) wb_addr_1 = 5'($urandom_range(0, 31));
      end
      cyc();
      if (i % 700 == 699) async_reset_check("rnd_arst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
